// File: rtl/servo_pwm_driver.sv
// servo_pwm_driver
// 50 Hz hobby-servo PWM generator. Each PWM period is 1024 phase steps of
// PRESCALE clock cycles. The duty command is clamped to a safe servo range
// and latched, together with the output enable, only on the last cycle of a
// period. The pulse in flight is therefore never cut short or stretched.
//
// Ports
//   clk25mhz          in   system clock, all state on rising edge
//   reset             in   asynchronous, active-low reset
//   enable            in   output enable, sampled at period boundaries only
//   duty_cycle_input  in   [9:0] commanded duty, 1 LSB = 1/1024 period
//   servoSignal       out  registered PWM output to the servo pin
//   period_strobe     out  one-cycle pulse after each boundary latch
//   duty_applied      out  [9:0] clamped duty currently being generated
module servo_pwm_driver #(
    parameter int PRESCALE     = 488,
    parameter int MIN_DUTY     = 41,
    parameter int MAX_DUTY     = 103,
    parameter int NEUTRAL_DUTY = 77
) (
    input  logic       clk25mhz,
    input  logic       reset,
    input  logic       enable,
    input  logic [9:0] duty_cycle_input,
    output logic       servoSignal,
    output logic       period_strobe,
    output logic [9:0] duty_applied
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [9:0]    MIN_D     = 10'(MIN_DUTY);
    localparam logic [9:0]    MAX_D     = 10'(MAX_DUTY);
    localparam logic [9:0]    NEUTRAL_D = 10'(NEUTRAL_DUTY);

    logic [PW-1:0] pre;
    logic [9:0]    phase;
    logic          en_applied;
    logic          tick;
    logic          boundary;
    logic [9:0]    duty_clamped;

    assign tick     = (pre == PRE_LAST);
    assign boundary = tick && (phase == 10'd1023);

    always_comb begin
        duty_clamped = duty_cycle_input;
        if (duty_cycle_input < MIN_D) begin
            duty_clamped = MIN_D;
        end else if (duty_cycle_input > MAX_D) begin
            duty_clamped = MAX_D;
        end
    end

    always_ff @(posedge clk25mhz or negedge reset) begin
        if (!reset) begin
            pre           <= '0;
            phase         <= '0;
            duty_applied  <= NEUTRAL_D;
            en_applied    <= 1'b0;
            servoSignal   <= 1'b0;
            period_strobe <= 1'b0;
        end else begin
            pre <= tick ? '0 : pre + PW'(1);
            if (tick) begin
                // 10-bit counter wraps 1023 -> 0 on its own
                phase <= phase + 10'd1;
            end
            if (boundary) begin
                duty_applied <= duty_clamped;
                en_applied   <= enable;
            end
            period_strobe <= boundary;
            // Uses pre-update duty/enable, so a new command first shapes the
            // pin on phase 0 of the following period.
            servoSignal   <= en_applied && (phase < duty_applied);
        end
    end

endmodule

// File: tb/tb_servo_pwm_driver.sv
module tb_servo_pwm_driver;

    localparam int PS = 4;
    localparam int P  = 1024 * PS;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [9:0] duty_cycle_input = 10'd77;
    logic       servoSignal;
    logic       period_strobe;
    logic [9:0] duty_applied;

    int n_chk  = 0;
    int n_fail = 0;

    servo_pwm_driver #(
        .PRESCALE    (PS),
        .MIN_DUTY    (41),
        .MAX_DUTY    (103),
        .NEUTRAL_DUTY(77)
    ) dut (
        .clk25mhz        (clk),
        .reset           (reset),
        .enable          (enable),
        .duty_cycle_input(duty_cycle_input),
        .servoSignal     (servoSignal),
        .period_strobe   (period_strobe),
        .duty_applied    (duty_applied)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int clamp(input int d);
        return (d < 41) ? 41 : ((d > 103) ? 103 : d);
    endfunction

    // Reference model: cnt = clock edges since reset release; phase and
    // boundaries follow from plain arithmetic on that count.
    int cnt = 0;
    int m_duty = 77;
    int m_en = 0;
    int m_servo = 0;
    int m_strobe = 0;
    int win_hi = 0;
    int gap = 0;
    int exp_w[$];
    int ph;
    int nxt;
    int wexp;

    initial exp_w.push_back(0);

    always @(negedge reset) begin
        cnt = 0; m_duty = 77; m_en = 0; m_servo = 0; m_strobe = 0;
        win_hi = 0; gap = 0;
        exp_w.delete();
        exp_w.push_back(0);
    end

    always @(posedge clk) begin
        if (reset) begin
            ph  = (cnt % P) / PS;
            nxt = (m_en != 0 && ph < m_duty) ? 1 : 0;
            m_strobe = ((cnt % P) == P - 1) ? 1 : 0;
            if (m_strobe != 0) begin
                m_duty = clamp(int'(duty_cycle_input));
                m_en   = int'(enable);
                exp_w.push_back(m_en != 0 ? m_duty * PS : 0);
            end
            m_servo = nxt;
            cnt++;
            #1;
            chk("servo", servoSignal, m_servo);
            chk("strobe", period_strobe, m_strobe);
            chk("duty_applied", duty_applied, m_duty);
            win_hi += int'(servoSignal);
            gap++;
            if (period_strobe) begin
                chk("strobe_gap", gap, P);
                wexp = (exp_w.size() > 0) ? exp_w.pop_front() : -1;
                chk("high_time", win_hi, wexp);
                gap = 0;
                win_hi = 0;
            end
        end
    end

    task automatic wait_mod(input int m);
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while ((cnt % P) != m && guard < 2 * P);
        chk("wait_bound", (guard < 2 * P) ? 1 : 0, 1);
    endtask

    function automatic logic [9:0] pick_duty();
        case ($urandom % 6)
            0:       return 10'($urandom_range(0, 40));
            1:       return 10'd41;
            2:       return 10'd103;
            3:       return 10'($urandom_range(104, 1023));
            default: return 10'($urandom_range(41, 103));
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        enable = 1'b1;
        duty_cycle_input = 10'd77;
        repeat (3) @(negedge clk);
        chk("rst_servo", servoSignal, 0);
        chk("rst_strobe", period_strobe, 0);
        chk("rst_duty", duty_applied, 77);
        reset = 1'b1;
        repeat (2 * P) @(negedge clk);

        // clamp cases
        duty_cycle_input = 10'd10;
        wait_mod(0);
        repeat (P - 10) @(negedge clk);
        duty_cycle_input = 10'd500;
        wait_mod(0);
        repeat (P - 10) @(negedge clk);
        duty_cycle_input = 10'd1023;
        wait_mod(0);

        // mid-period change and change on the boundary cycle itself
        wait_mod(P - 100);
        duty_cycle_input = 10'd51;
        wait_mod(20 * PS);
        duty_cycle_input = 10'd92;
        wait_mod(P - 1);
        duty_cycle_input = 10'd60;
        @(negedge clk);
        duty_cycle_input = 10'd92;

        // enable drop mid-period
        wait_mod(30 * PS);
        enable = 1'b0;
        wait_mod(P - 1);
        wait_mod(P - 1);

        // asynchronous reset mid-pulse
        enable = 1'b1;
        duty_cycle_input = 10'd92;
        wait_mod(P - 1);
        wait_mod(10 * PS + 1);
        chk("pre_rst_servo", servoSignal, 1);
        chk("pre_rst_duty", duty_applied, 92);
        #2;
        reset = 1'b0;
        #1;
        chk("async_servo", servoSignal, 0);
        chk("async_duty", duty_applied, 77);
        chk("async_strobe", period_strobe, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // randomized commands, including boundary-cycle arrivals
        for (int p = 0; p < 5; p++) begin
            for (int k = 0; k < 2; k++) begin
                repeat ($urandom_range(1, 1500)) @(negedge clk);
                duty_cycle_input = pick_duty();
                enable = ($urandom % 5) != 0;
            end
            wait_mod(P - 1);
            duty_cycle_input = pick_duty();
            enable = ($urandom % 5) != 0;
            @(negedge clk);
            duty_cycle_input = pick_duty();
        end
        wait_mod(P - 1);
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
